// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// fixed latency (iterations plus the FIX and DONE cycles).
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int FIX_CYCLES    = 1;
    localparam int DONE_CYCLES   = 1;
    localparam int LATENCY_EXTRA = FIX_CYCLES + DONE_CYCLES;

    function automatic int latency(input int size);
        return size + LATENCY_EXTRA;
    endfunction

endpackage

// File: rtl/seq_divider_adder.sv
// Plain ripple-style adder with carry in/out; the divider uses it as its
// trial subtractor by feeding the inverted divisor and cin = 1.
module seq_divider_adder #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/seq_divider.sv
// Restoring sequential divider, one quotient bit per cycle, fixed latency.
// Signed operation is compiled in only when SEQ_DIVIDER_SIGNED_EN is defined.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            is_signed,
    input  logic [SIZE-1:0] X,
    input  logic [SIZE-1:0] Y,
    output logic [SIZE-1:0] Q,
    output logic [SIZE-1:0] R,
    output logic            busy,
    output logic            done
);

    localparam int ITERS = latency(SIZE) - LATENCY_EXTRA;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITERS - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SIZE-1:0]  rem_q, rem_d;
    logic [SIZE-1:0]  quo_q, quo_d;
    logic [SIZE-1:0]  div_q, div_d;
    logic [SIZE-1:0]  q_out_q, q_out_d;
    logic [SIZE-1:0]  r_out_q, r_out_d;

    logic [SIZE:0]    trial_a, trial_b, trial_diff;
    logic             trial_cout;
    logic             trial_msb_unused;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             div_zero_q, div_zero_d;
    logic             x_neg, y_neg;

    assign x_neg = is_signed & X[SIZE-1];
    assign y_neg = is_signed & Y[SIZE-1];
`else
    logic             is_signed_unused;

    assign is_signed_unused = is_signed;
`endif

    // Shifted partial remainder minus divisor; a carry out means no borrow.
    assign trial_a = {rem_q, quo_q[SIZE-1]};
    assign trial_b = ~{1'b0, div_q};

    seq_divider_adder #(
        .WIDTH (SIZE + 1)
    ) u_trial_sub (
        .a    (trial_a),
        .b    (trial_b),
        .cin  (1'b1),
        .sum  (trial_diff),
        .cout (trial_cout)
    );

    assign trial_msb_unused = trial_diff[SIZE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            q_out_q    <= '0;
            r_out_q    <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            q_out_q    <= q_out_d;
            r_out_q    <= r_out_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div_zero_q <= div_zero_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        q_out_d    = q_out_q;
        r_out_d    = r_out_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div_zero_d = div_zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    rem_d   = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                    quo_d      = x_neg ? -X : X;
                    div_d      = y_neg ? -Y : Y;
                    q_neg_d    = x_neg ^ y_neg;
                    r_neg_d    = x_neg;
                    div_zero_d = (Y == '0);
`else
                    quo_d = X;
                    div_d = Y;
`endif
                end
            end
            // The dividend register shifts out MSB-first while quotient bits shift in.
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (trial_cout) begin
                    rem_d = trial_diff[SIZE-1:0];
                    quo_d = {quo_q[SIZE-2:0], 1'b1};
                end else begin
                    rem_d = trial_a[SIZE-1:0];
                    quo_d = {quo_q[SIZE-2:0], 1'b0};
                end
                if (cnt_q == LAST_ITER) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = DONE;
`ifdef SEQ_DIVIDER_SIGNED_EN
                q_out_d = (q_neg_q && !div_zero_q) ? -quo_q : quo_q;
                r_out_d = r_neg_q ? -rem_q : rem_q;
`else
                q_out_d = quo_q;
                r_out_d = rem_q;
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Q    = q_out_q;
    assign R    = r_out_q;
    assign busy = (state_q == CALC) || (state_q == FIX);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: an arithmetic reference model predicts
// busy/done timing and Q/R every cycle, plus hand-computed directed cases.
module tb_seq_divider;

    localparam int W   = 32;
    localparam int LAT = W + 2;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam bit SIGNED_BUILD = 1'b1;
`else
    localparam bit SIGNED_BUILD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] X, Y;
    logic [W-1:0] Q, R;
    logic         busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles since the accepting edge (0 = idle).
    int           m_cyc = 0;
    logic [W-1:0] m_q, m_r;
    logic [W-1:0] m_hold_q = '0;
    logic [W-1:0] m_hold_r = '0;

    seq_divider #(.SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .X         (X),
        .Y         (Y),
        .Q         (Q),
        .R         (R),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Division result straight from the arithmetic rules, including the
    // divide-by-zero and signed-overflow conventions.
    function automatic logic [2*W-1:0] model_div(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W-1:0] q, r;
        logic         sm;
        sm = s && SIGNED_BUILD;
        if (y == '0) begin
            q = '1;
            r = x;
        end else if (sm && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            q = x;
            r = '0;
        end else if (sm) begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
        end else begin
            q = x / y;
            r = x % y;
        end
        return {q, r};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc    = 0;
            m_hold_q = '0;
            m_hold_r = '0;
        end else if (m_cyc == 0) begin
            if (start) begin
                {m_q, m_r} = model_div(X, Y, is_signed);
                m_cyc = 1;
            end
        end else if (m_cyc == LAT) begin
            m_hold_q = m_q;
            m_hold_r = m_r;
            m_cyc    = 0;
        end else begin
            m_cyc++;
        end
    end

    // Single compare process: flags every cycle, results in DONE and while idle.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_cyc >= 1 && m_cyc < LAT) begin
                checkOutput("busy_done_inflight", {30'b0, busy, done}, 32'd2);
            end else if (m_cyc == LAT) begin
                checkOutput("busy_done_done", {30'b0, busy, done}, 32'd1);
                checkOutput("Q_model", Q, m_q);
                checkOutput("R_model", R, m_r);
            end else begin
                checkOutput("busy_done_idle", {30'b0, busy, done}, 32'd0);
                checkOutput("Q_hold", Q, m_hold_q);
                checkOutput("R_hold", R, m_hold_r);
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        @(negedge clk);
        X         = x;
        Y         = y;
        is_signed = s;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic waitDone(input int cnt_in, output int lat);
        lat = cnt_in;
        while (!done && lat < 4 * LAT) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic runDirected(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                               input logic s, input logic [W-1:0] eq, input logic [W-1:0] er);
        int lat;
        applyStimulus(x, y, s);
        waitDone(1, lat);
        checkOutput({name, "_latency"}, 32'(lat), 32'(LAT));
        checkOutput({name, "_Q"}, Q, eq);
        checkOutput({name, "_R"}, R, er);
    endtask

    initial begin
        int lat;
        int n;
        int k;
        logic [W-1:0] rx, ry;
        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        X         = '0;
        Y         = '0;

        #12;
        checkOutput("reset_Q", Q, 32'd0);
        checkOutput("reset_R", R, 32'd0);
        checkOutput("reset_flags", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] directed cases");
        runDirected("u_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);
        runDirected("s_m100_7", -32'sd100, 32'd7, 1'b1,
                    SIGNED_BUILD ? 32'hFFFF_FFF2 : 32'h2492_4916,
                    SIGNED_BUILD ? 32'hFFFF_FFFE : 32'd2);
        runDirected("s_500_m450", 32'd500, -32'sd450, 1'b1,
                    SIGNED_BUILD ? 32'hFFFF_FFFF : 32'd0,
                    SIGNED_BUILD ? 32'd50 : 32'd500);
        runDirected("u_500_0", 32'd500, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd500);
        runDirected("s_500_0", 32'd500, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd500);
        runDirected("s_m7_0", -32'sd7, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9);
        runDirected("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                    SIGNED_BUILD ? 32'h8000_0000 : 32'd0,
                    SIGNED_BUILD ? 32'd0 : 32'h8000_0000);
        runDirected("u_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);

        $display("[TB] start pulsed while busy");
        applyStimulus(32'd1000, 32'd33, 1'b0);
        repeat (9) @(negedge clk);
        X     = 32'd77;
        Y     = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(11, lat);
        checkOutput("busy_start_latency", 32'(lat), 32'(LAT));
        checkOutput("busy_start_Q", Q, 32'd30);
        checkOutput("busy_start_R", R, 32'd10);
        repeat (LAT + 4) @(negedge clk);
        checkOutput("busy_start_not_run", {30'b0, busy, done}, 32'd0);

        $display("[TB] randomized operations");
        for (int i = 0; i < 60; i++) begin
            rx = $urandom;
            case ($urandom_range(0, 5))
                0: ry = '0;
                1: ry = W'($urandom_range(1, 15));
                2: ry = -W'($urandom_range(1, 15));
                3: ry = $urandom;
                4: begin rx = 32'h8000_0000; ry = '1; end
                default: ry = $urandom >> $urandom_range(0, 31);
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(rx, ry, 1'($urandom_range(0, 1)));
            n = 1;
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(2, 20);
                repeat (k) @(negedge clk);
                X     = $urandom;
                Y     = $urandom;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                n = 1 + k + 1;
            end
            waitDone(n, lat);
            checkOutput("rand_latency", 32'(lat), 32'(LAT));
        end

        $display("[TB] reset during CALC");
        applyStimulus(32'd123456, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_async_Q", Q, 32'd0);
        checkOutput("rst_async_R", R, 32'd0);
        checkOutput("rst_async_flags", {30'b0, busy, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        checkOutput("rst_no_done", {30'b0, busy, done}, 32'd0);
        runDirected("after_rst_950_1000", 32'd950, 32'd1000, 1'b0, 32'd0, 32'd950);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
